// File: rtl/ascon_xor_begin.sv
// ascon_xor_begin: pre-permutation XOR stage of the ASCON-128 datapath.
// XORs the data block into state word 0 and the key into words 1/2,
// then registers the result (1-cycle latency, one new input per cycle).
// The state is five 64-bit words, word w at [w], so word 0 is the lowest 64 bits.
// Optional macro XOR_BEGIN_VALID_EN adds valid_i/valid_o; state_o then
// captures only on edges where valid_i is high.

package ascon_pack;
  localparam int NUM_WORDS = 5;
  localparam int WORD_W    = 64;
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] type_state;
endpackage

// One state word: conditional bitwise XOR with its mask.
module ascon_xor_begin_lane #(
  parameter int VEC_W = 64
) (
  input  logic             en,
  input  logic [VEC_W-1:0] word_i,
  input  logic [VEC_W-1:0] mask_i,
  output logic [VEC_W-1:0] word_o
);
  // Gate the mask with the enable, no carries anywhere.
  always_comb word_o = word_i ^ (en ? mask_i : '0);
endmodule

module ascon_xor_begin (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            en_xor_data_i,
  input  logic            en_xor_key_i,
  input  logic [63:0]     data_i,
  input  logic [127:0]    key_i,
  input  logic [4:0][63:0] state_i,
  output logic [4:0][63:0] state_o
`ifdef XOR_BEGIN_VALID_EN
  ,
  input  logic            valid_i,
  output logic            valid_o
`endif
);
  import ascon_pack::*;

  localparam int NUM_LANES = NUM_WORDS;
  localparam int VEC_W     = WORD_W;

  logic [NUM_LANES-1:0]            lane_en;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_mask;
  type_state                       nxt;

  // Word 0 takes the data block, words 1/2 take the key MSB-first,
  // words 3/4 always pass through.
  always_comb begin
    lane_en      = '0;
    lane_mask    = '0;
    lane_en[0]   = en_xor_data_i;
    lane_mask[0] = data_i;
    lane_en[1]   = en_xor_key_i;
    lane_mask[1] = key_i[127:64];
    lane_en[2]   = en_xor_key_i;
    lane_mask[2] = key_i[63:0];
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      ascon_xor_begin_lane #(.VEC_W(VEC_W)) u_lane (
        .en     (lane_en[g]),
        .word_i (state_i[g]),
        .mask_i (lane_mask[g]),
        .word_o (nxt[g])
      );
    end
  endgenerate

`ifdef XOR_BEGIN_VALID_EN
  localparam int STAGES = 1;
  logic [STAGES:0] vld_pipe;

  always_comb vld_pipe[0] = valid_i;

  // Valid follows input by one cycle; state captures only on valid edges.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      vld_pipe[STAGES:1] <= '0;
      state_o            <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (valid_i) state_o <= nxt;
    end
  end

  assign valid_o = vld_pipe[STAGES];
`else
  // Capture the XORed state on every edge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_o <= '0;
    else         state_o <= nxt;
  end
`endif

endmodule

// File: tb/tb_ascon_xor_begin.sv
// Self-checking bench for ascon_xor_begin: fixed vector table, reset and
// between-edge sequences, then random traffic against a 320-bit mask model.
`timescale 1ns/1ps
module tb_ascon_xor_begin;
  logic            clock_i = 1'b0;
  logic            reset_i = 1'b0;
  logic            en_xor_data_i = 1'b0;
  logic            en_xor_key_i = 1'b0;
  logic [63:0]     data_i = '0;
  logic [127:0]    key_i = '0;
  logic [4:0][63:0] state_i = '0;
  logic [4:0][63:0] state_o;
  logic            valid_i = 1'b1;
  logic            valid_o;

  int total = 0;
  int bad   = 0;

  always #5 clock_i = ~clock_i;

  ascon_xor_begin dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .en_xor_data_i (en_xor_data_i),
    .en_xor_key_i  (en_xor_key_i),
    .data_i        (data_i),
    .key_i         (key_i),
    .state_i       (state_i),
    .state_o       (state_o)
`ifdef XOR_BEGIN_VALID_EN
    ,
    .valid_i       (valid_i),
    .valid_o       (valid_o)
`endif
  );

`ifndef XOR_BEGIN_VALID_EN
  assign valid_o = 1'b0;
`endif

  typedef struct {
    string        name;
    logic         en_d;
    logic         en_k;
    logic [63:0]  data;
    logic [127:0] key;
    logic [319:0] st;
    logic [319:0] exp;
  } vec_t;

  // Reference: whole state XORed with a 320-bit mask laid out word 0 lowest.
  function automatic logic [319:0] model(input logic ed, input logic ek,
      input logic [63:0] d, input logic [127:0] k, input logic [319:0] s);
    logic [319:0] m;
    m = {128'h0, (ek ? {k[63:0], k[127:64]} : 128'h0), (ed ? d : 64'h0)};
    return s ^ m;
  endfunction

  task automatic check(input string nm, input logic [319:0] act, input logic [319:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, req);
    end
  endtask

  // Pack words listed w0..w4 into the packed layout (w0 lowest).
  function automatic logic [319:0] st5(input logic [63:0] w0, w1, w2, w3, w4);
    return {w4, w3, w2, w1, w0};
  endfunction

  task automatic drive(input logic ed, input logic ek, input logic [63:0] d,
      input logic [127:0] k, input logic [319:0] s);
    en_xor_data_i = ed;
    en_xor_key_i  = ek;
    data_i        = d;
    key_i         = k;
    state_i       = s;
  endtask

  vec_t vecs[4];
  logic [319:0] sa, sb, exp_v, held;
  logic [127:0] kk;
  logic [63:0]  dd;

  initial begin
    sa = st5(64'h1fc9a149abfd3af5, 64'hdbf2eef89f61a7c5, 64'h7d53f3d9dd22530a,
             64'h6654c154e6e248f1, 64'h169557420d2a6714);
    sb = st5(64'h4608da0e76fcee25, 64'h876f2d998dd3ed21, 64'h5d5b8b59b7ac16ee,
             64'he23c656f97f63dc8, 64'h3e09499302483746);
    kk = 128'h000102030405060708090A0B0C0D0E0F;
    dd = 64'h436F6E636576657A;

    vecs[0] = '{"pass", 1'b0, 1'b0, dd, kk, sa, sa};
    vecs[1] = '{"key", 1'b0, 1'b1, dd, kk, sa,
      st5(64'h1fc9a149abfd3af5, 64'hdbf3ecfb9b64a1c2, 64'h755af9d2d12f5d05,
          64'h6654c154e6e248f1, 64'h169557420d2a6714)};
    vecs[2] = '{"data", 1'b1, 1'b0, dd, kk, sb,
      st5(64'h0567b46d138a8b5f, 64'h876f2d998dd3ed21, 64'h5d5b8b59b7ac16ee,
          64'he23c656f97f63dc8, 64'h3e09499302483746)};
    vecs[3] = '{"both", 1'b1, 1'b1, dd, kk, sb,
      st5(64'h0567b46d138a8b5f, 64'h876e2f9a89d6eb26, 64'h55528152bba118e1,
          64'he23c656f97f63dc8, 64'h3e09499302483746)};

    // Asynchronous reset with nonzero input: zero before any edge.
    drive(1'b1, 1'b1, dd, kk, sa);
    #2 reset_i = 1'b1;
    #1 check("rst_async", state_o, '0);
    check1("rst_valid", valid_o, 1'b0);
    @(posedge clock_i); #1;
    check("rst_hold", state_o, '0);
    @(negedge clock_i);
    reset_i = 1'b0;
    // First capture on the first edge after release uses the enables then present.
    @(posedge clock_i); #1;
    check("rst_first", state_o, model(1'b1, 1'b1, dd, kk, sa));

    // Fixed vectors, one edge each.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_i);
      drive(vecs[i].en_d, vecs[i].en_k, vecs[i].data, vecs[i].key, vecs[i].st);
      @(posedge clock_i); #1;
      check(vecs[i].name, state_o, vecs[i].exp);
    end

    // Input changes between edges do not reach state_o.
    held = state_o;
    @(negedge clock_i);
    drive(1'b0, 1'b0, 64'h0, 128'h0, '1);
    #2 check("between_edges", state_o, held);
    @(posedge clock_i); #1;
    check("after_edge", state_o, {320{1'b1}});

    // Mid-operation async reset.
    @(negedge clock_i);
    drive(1'b1, 1'b0, dd, kk, sb);
    #1 reset_i = 1'b1;
    #1 check("rst_mid", state_o, '0);
    @(negedge clock_i);
    reset_i = 1'b0;
    @(posedge clock_i); #1;
    check("rst_mid_rel", state_o, vecs[2].exp);

`ifdef XOR_BEGIN_VALID_EN
    // Valid low: state holds while inputs change.
    held = state_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_i);
      valid_i = 1'b0;
      drive(i[0], i[1], $urandom, {$urandom, $urandom, $urandom, $urandom}, {10{$urandom}});
      @(posedge clock_i); #1;
      check("vld_hold", state_o, held);
      check1("vld_o_low", valid_o, 1'b0);
    end
    @(negedge clock_i);
    valid_i = 1'b1;
    drive(1'b1, 1'b1, dd, kk, sb);
    @(posedge clock_i); #1;
    check("vld_cap", state_o, vecs[3].exp);
    check1("vld_o_high", valid_o, 1'b1);
`endif

    // Random traffic, enables independent; valid kept high.
    for (int n = 0; n < 200; n++) begin
      logic ed, ek;
      logic [63:0] d;
      logic [127:0] k;
      logic [319:0] s;
      ed = $urandom_range(0, 1);
      ek = $urandom_range(0, 1);
      d  = {$urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      s  = {10{$urandom}};
      for (int w = 0; w < 10; w++) s[w*32 +: 32] = $urandom;
      @(negedge clock_i);
      valid_i = 1'b1;
      drive(ed, ek, d, k, s);
      exp_v = model(ed, ek, d, k, s);
      @(posedge clock_i); #1;
      check("random", state_o, exp_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
